// File: rtl/div_pkg.sv
// Shared definitions for the two-requester divider scheduler: FSM encoding,
// default widths/watchdog limit and the requester ID type.
package div_pkg;

  localparam int DEF_W       = 1024;
  localparam int DEF_DW      = DEF_W + 2;
  localparam int DEF_TIMEOUT = 4200;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/div_sched_if.sv
// One requester's operand handshake plus its result strobe; the scheduler
// takes the slave side, a requester drives the master side.
interface div_sched_if #(
  parameter int W  = div_pkg::DEF_W,
  parameter int DW = W + 2
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] dividend;
  logic [W-1:0]  divisor;
  logic          rsp_valid;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          err;

  modport master (
    output valid, dividend, divisor,
    input  ready, rsp_valid, quotient, remainder, err
  );

  modport slave (
    input  valid, dividend, divisor,
    output ready, rsp_valid, quotient, remainder, err
  );
endinterface

// File: rtl/div_rr_pick.sv
// Two-input round-robin picker: a lone requester always wins, a tie goes to
// the requester named by the pointer.
module div_rr_pick
  import div_pkg::*;
(
  input  logic [1:0] i_valid,
  input  req_id_t    i_ptr,
  output req_id_t    o_gnt,
  output logic       o_any
);

  always_comb begin
    o_any = |i_valid;
    if (&i_valid) o_gnt = i_ptr;
    else          o_gnt = i_valid[1];
  end

endmodule

// File: rtl/div_sched.sv
// Arbitrates two requesters onto one external divider, one operation in flight.
// Define DIV_SCHED_TIMEOUT_EN to add a watchdog that aborts a stalled divide.
module div_sched
  import div_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DW      = W + (DEF_DW - DEF_W),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  div_sched_if.slave    req0,
  div_sched_if.slave    req1,
  output logic          div_start,
  output logic [DW-1:0] div_dividend,
  output logic [W-1:0]  div_divisor,
  input  logic          div_done,
  input  logic [W-1:0]  div_quotient,
  input  logic [W-1:0]  div_remainder,
  output logic          busy
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_t              r_state, w_next;
  req_id_t             r_ptr, r_id, w_gnt;
  logic                w_any, w_tmo, w_enter_resp;
  logic [DW-1:0]       r_dvd;
  logic [W-1:0]        r_dvs;
  logic [1:0][W-1:0]   r_q, r_r;
  logic [1:0]          r_e;
  logic [W-1:0]        w_res_q, w_res_r;
  logic                w_res_e;

  div_rr_pick u_pick (
    .i_valid ({req1.valid, req0.valid}),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_any   (w_any)
  );

`ifdef DIV_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Held at zero outside WAIT, so every WAIT entry starts a fresh count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_cnt <= '0;
    else if (r_state != S_WAIT) r_cnt <= '0;
    else if (!div_done)         r_cnt <= r_cnt + 1'b1;
  end

  assign w_tmo = (r_state == S_WAIT) && !div_done && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_LAUNCH;
      S_LAUNCH: w_next = (r_dvs == '0) ? S_RESP : S_WAIT;
      S_WAIT:   if (div_done || w_tmo) w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Divide-by-zero and watchdog expiry both report err with zeroed results.
  always_comb begin
    w_res_q = '0;
    w_res_r = '0;
    w_res_e = 1'b1;
    if (r_state == S_WAIT && div_done) begin
      w_res_q = div_quotient;
      w_res_r = div_remainder;
      w_res_e = 1'b0;
    end
  end

  assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
      r_id  <= 1'b0;
      r_dvd <= '0;
      r_dvs <= '0;
      r_q   <= '0;
      r_r   <= '0;
      r_e   <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_id  <= w_gnt;
        r_dvd <= w_gnt ? req1.dividend : req0.dividend;
        r_dvs <= w_gnt ? req1.divisor  : req0.divisor;
      end
      if (w_enter_resp) begin
        r_q[r_id] <= w_res_q;
        r_r[r_id] <= w_res_r;
        r_e[r_id] <= w_res_e;
      end
      if (r_state == S_RESP) r_ptr <= ~r_id;
    end
  end

  // ready is combinational so the grant and the operand latch share one cycle.
  always_comb begin
    busy           = (r_state != S_IDLE);
    div_start      = (r_state == S_LAUNCH) && (r_dvs != '0);
    req0.ready     = !rst && (r_state == S_IDLE) && w_any && (w_gnt == 1'b0);
    req1.ready     = !rst && (r_state == S_IDLE) && w_any && (w_gnt == 1'b1);
    req0.rsp_valid = (r_state == S_RESP) && (r_id == 1'b0);
    req1.rsp_valid = (r_state == S_RESP) && (r_id == 1'b1);
  end

  assign div_dividend   = r_dvd;
  assign div_divisor    = r_dvs;
  assign req0.quotient  = r_q[0];
  assign req0.remainder = r_r[0];
  assign req0.err       = r_e[0];
  assign req1.quotient  = r_q[1];
  assign req1.remainder = r_r[1];
  assign req1.err       = r_e[1];

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural fixed-latency divider.
module tb_div_sched;

  localparam int W   = 1024;
  localparam int DW  = W + 2;
  localparam int TO  = 64;
  localparam int D   = 10;
  localparam int LIM = 400;

  logic          clk = 1'b0;
  logic          rst;
  logic          div_start, div_done, busy;
  logic [DW-1:0] div_dividend;
  logic [W-1:0]  div_divisor, div_quotient, div_remainder;

  div_sched_if #(.W(W), .DW(DW)) rq0 ();
  div_sched_if #(.W(W), .DW(DW)) rq1 ();

  div_sched #(.W(W), .DW(DW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (rq0),
    .req1          (rq1),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_done      (div_done),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_start = 0, t_start = -1, n_rsp0 = 0, n_rsp1 = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) begin
      n_start <= n_start + 1;
      t_start <= cyc;
    end
    if (rq0.rsp_valid) n_rsp0 <= n_rsp0 + 1;
    if (rq1.rsp_valid) n_rsp1 <= n_rsp1 + 1;
  end

  // Behavioural divider: div_done rises D cycles after the div_start cycle.
  logic          m_busy = 1'b0, m_done = 1'b0, m_inj, m_hold;
  int            m_cnt = 0;
  logic [DW-1:0] m_a = '0;
  logic [W-1:0]  m_b = '1;

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (rst) m_busy <= 1'b0;
    else if (div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= D - 1;
      m_a    <= div_dividend;
      m_b    <= div_divisor;
    end else if (m_busy && !m_hold) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end else m_cnt <= m_cnt - 1;
    end
  end

  assign div_done      = m_done | m_inj;
  assign div_quotient  = W'(m_a / DW'(m_b));
  assign div_remainder = W'(m_a % DW'(m_b));

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [DW-1:0] a, input logic [W-1:0] b);
    if (id == 0) begin
      rq0.valid = v; rq0.dividend = a; rq0.divisor = b;
    end else begin
      rq1.valid = v; rq1.dividend = a; rq1.divisor = b;
    end
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? rq0.ready : rq1.ready;
  endfunction

  function automatic logic rspv(input int id);
    return (id == 0) ? rq0.rsp_valid : rq1.rsp_valid;
  endfunction

  task automatic wait_rdy(input int id, output int t);
    t = -1;
    for (int i = 0; i < LIM; i++) begin
      #1;
      if (rdy(id)) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int id, input int lim, output int t);
    t = -1;
    for (int i = 0; i < lim; i++) begin
      #1;
      if (rspv(id)) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) chk("rsp_timeout", 0, 1);
  endtask

  task automatic run_op(input int id, input logic [DW-1:0] a, input logic [W-1:0] b,
                        input int lim, output int t_rdy, output int t_rsp);
    set_req(id, 1'b1, a, b);
    wait_rdy(id, t_rdy);
    tick();
    set_req(id, 1'b0, '0, '0);
    wait_rsp(id, lim, t_rsp);
  endtask

  initial begin
    #400000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, ns, n0, nb;
    logic [W-1:0]  key, exp_r;
    logic [DW-1:0] big;

    rst = 1'b1; m_inj = 1'b0; m_hold = 1'b0;
    set_req(0, 1'b0, '0, '0);
    set_req(1, 1'b0, '0, '0);
    repeat (2) tick();
    #1;
    chk("rst_busy",      busy, 0);
    chk("rst_div_start", div_start, 0);
    chk("rst_dividend",  div_dividend, 0);
    chk("rst_rsp0",      rq0.rsp_valid, 0);
    chk("rst_quot0",     rq0.quotient, 0);
    rq0.valid = 1'b1;
    #1;
    chk("rst_ready0_gated", rq0.ready, 0);
    rq0.valid = 1'b0;
    rst = 1'b0;
    tick();

    // Simultaneous pair straight after reset: pointer 0 favours req0.
    set_req(0, 1'b1, 40, 6);
    set_req(1, 1'b1, 50, 8);
    wait_rdy(0, t0);
    chk("pair_ready1_low", rq1.ready, 0);
    tick();
    set_req(0, 1'b1, 90, 9);
    wait_rsp(0, LIM, t1);
    chk("pair_rsp0_lat", t1 - t0, 12);
    chk("pair_q0", rq0.quotient, 6);
    chk("pair_r0", rq0.remainder, 4);
    tick();
    #1;
    chk("pair2_ready1", rq1.ready, 1);
    chk("pair2_ready0_low", rq0.ready, 0);
    tick();
    set_req(1, 1'b0, '0, '0);
    wait_rsp(1, LIM, t1);
    chk("pair2_q1", rq1.quotient, 6);
    chk("pair2_r1", rq1.remainder, 2);
    chk("hold_q0", rq0.quotient, 6);
    tick();
    #1;
    chk("pair3_ready0", rq0.ready, 1);
    tick();
    set_req(0, 1'b0, '0, '0);
    wait_rsp(0, LIM, t1);
    chk("pair3_q0", rq0.quotient, 10);
    chk("pair3_r0", rq0.remainder, 0);

    // Basic divide, D = 10.
    tick();
    ns = n_start;
    run_op(0, 100, 7, LIM, t0, t1);
    chk("basic_start_cyc", t_start, t0 + 1);
    chk("basic_lat", t1 - t0, 12);
    chk("basic_q", rq0.quotient, 14);
    chk("basic_r", rq0.remainder, 2);
    chk("basic_err", rq0.err, 0);
    chk("basic_nstart", n_start - ns, 1);

    // Divide by zero skips the divider.
    tick();
    ns = n_start;
    run_op(1, 55, 0, LIM, t0, t1);
    chk("dz_lat", t1 - t0, 2);
    chk("dz_err", rq1.err, 1);
    chk("dz_q", rq1.quotient, 0);
    chk("dz_r", rq1.remainder, 0);
    chk("dz_nstart", n_start - ns, 0);

    // 2^1024 by a 1024-bit modulus with its top bit set: quotient 1, remainder 2^1024 - key.
    key = {128'hD4C1_8B2F_6A93_07E5_5F1D_C2A8_9B40_736E,
           128'h1E6F_A0B7_3C52_D98E_4471_0F2A_BC63_95D8,
           128'h7A0E_C3F1_2859_B64D_E017_6A3C_F289_514B,
           128'h3B8D_E6A4_0C71_F925_86BE_13D0_4FA7_2C69,
           128'h95E2_4D0A_B817_6FC3_2A58_E194_07DB_C36F,
           128'h0F47_B2A9_E865_1DC3_7B04_5EA2_C91F_6830,
           128'hA6D1_3F8E_5274_C09B_E3A8_1D65_4BF0_72C9,
           128'h4E93_07BA_D612_8F5C_31A7_E40D_96B2_5C3B};
    exp_r = ~key + 1'b1;
    big = '0;
    big[1024] = 1'b1;
    tick();
    run_op(0, big, key, LIM, t0, t1);
    chk("rsa_q", rq0.quotient, 1);
    chk("rsa_rem_hi", rq0.remainder[1023:512], exp_r[1023:512]);
    chk("rsa_rem_lo", rq0.remainder[511:0], exp_r[511:0]);
    chk("rsa_err", rq0.err, 0);

    // Divider never answers.
    m_hold = 1'b1;
    tick();
`ifdef DIV_SCHED_TIMEOUT_EN
    run_op(0, 100, 7, TO + 50, t0, t1);
    chk("tmo_lat", t1 - (t0 + 2), TO);
    chk("tmo_err", rq0.err, 1);
    chk("tmo_q", rq0.quotient, 0);
    tick();
    set_req(0, 1'b1, 100, 7);
    wait_rdy(0, t0);
    tick();
    set_req(0, 1'b0, '0, '0);
    repeat (5) tick();
`else
    set_req(0, 1'b1, 100, 7);
    wait_rdy(0, t0);
    tick();
    set_req(0, 1'b0, '0, '0);
    nb = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      #1;
      if (busy) nb++;
    end
    chk("nowd_busy_hold", nb, 200);
    tick();
`endif

    // Asynchronous reset in WAIT, then a stale div_done.
    n0 = n_rsp0;
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_dividend", div_dividend, 0);
    chk("arst_divisor", div_divisor, 0);
    chk("arst_q0", rq0.quotient, 0);
    chk("arst_err0", rq0.err, 0);
    tick();
    rst = 1'b0;
    m_hold = 1'b0;
    m_inj = 1'b1;
    tick();
    m_inj = 1'b0;
    repeat (3) tick();
    #1;
    chk("arst_no_rsp", n_rsp0 - n0, 0);
    chk("arst_idle", busy, 0);
    tick();
    run_op(0, 100, 7, LIM, t0, t1);
    chk("post_lat", t1 - t0, 12);
    chk("post_q", rq0.quotient, 14);
    chk("post_r", rq0.remainder, 2);
    tick();
    chk("post_nrsp", n_rsp0 - n0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
